uart_reg_bridge: RTL and testbench
==================================

Name: uart_reg_bridge

Overview:
Parametrised UART-to-register-bus command bridge, the successor to the single-word UART/AES bridge. It sits between a byte-level UART receiver/transmitter pair and any memory-mapped peripheral (AES core, future crypto cores).
- Generalised address and data width; adds burst transfers with address auto-increment.
- Every command returns a status byte; inter-byte timeout recovery; configurable bus read latency.

Parameters:
ADDR_BYTES, 1, address bytes per frame (1..4); bus_addr width = 8*ADDR_BYTES
DATA_BYTES, 4, bytes per bus word (1..8); bus word width = 8*DATA_BYTES
MAX_BURST, 16, max words per burst command (1..255)
READ_LAT, 1, cycles from read strobe to valid bus_rdata (1..4)
TIMEOUT_CYC, 100000, max clk cycles between received bytes inside a frame

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
rx_valid  in  1  one-cycle pulse, rx_data valid; no backpressure
rx_data  in  8  received byte
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter can accept; transfer when tx_valid && tx_ready
tx_data  out  8  byte to transmit
bus_cs  out  1  one-cycle access strobe
bus_we  out  1  1 = write, 0 = read; qualified by bus_cs
bus_addr  out  8*ADDR_BYTES  word address
bus_wdata  out  8*DATA_BYTES  write data
bus_rdata  in  8*DATA_BYTES  read data, valid READ_LAT cycles after read strobe
busy  out  1  high whenever state != IDLE
err_cnt  out  8  saturating count of error responses sent

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. On rst, all outputs are 0, the FSM goes to IDLE, and any partial frame or pending response is discarded (even mid-burst or mid-transmit).
- Frame format: CMD, ADDR (ADDR_BYTES, LSB first), then per opcode. All multi-byte fields are LSB first.
  - 0x01 write: DATA_BYTES data.
  - 0x02 read: no further bytes.
  - 0x03 burst write: LEN byte, then LEN*DATA_BYTES data.
  - 0x04 burst read: LEN byte.
- Status bytes: 0xA5 OK, 0xE1 bad opcode, 0xE2 timeout, 0xE3 bad LEN (0 or > MAX_BURST).
- Write commands: OK is sent after the last bus write.
- Read commands: OK is sent first, then each word's DATA_BYTES bytes LSB first.
- States: IDLE, ADDR, LEN, DATA, BUS_WR, BUS_RD, RD_WAIT, TX_STAT, TX_DATA.
- Transitions:
  - IDLE: on rx_valid, latch CMD. Valid opcode -> ADDR. Invalid opcode -> TX_STAT(0xE1); no further bytes are consumed for that frame.
  - ADDR -> LEN (opcodes 0x03/0x04) or DATA (0x01) or BUS_RD (0x02), after the last address byte.
  - LEN: 0 or > MAX_BURST -> TX_STAT(0xE3). Otherwise DATA (0x03) or BUS_RD (0x04). Opcodes 0x01/0x02 use an implicit LEN of 1.
  - DATA -> BUS_WR once DATA_BYTES bytes are assembled.
  - BUS_WR: one cycle with bus_cs=1, bus_we=1. Then increment address (+1, wraps modulo 2^(8*ADDR_BYTES)) and decrement remaining count. Next is DATA if count remains, else TX_STAT(0xA5).
  - BUS_RD: one cycle with bus_cs=1, bus_we=0, then RD_WAIT for READ_LAT cycles. Capture bus_rdata in the final RD_WAIT cycle, then go to TX_DATA. For the first word, TX_STAT(0xA5) precedes TX_DATA.
  - TX_DATA: after DATA_BYTES bytes accepted, increment address. Next is BUS_RD if words remain, else IDLE.
  - TX_STAT -> IDLE after acceptance, except OK for a read, which continues to BUS_RD/TX_DATA.
- Response ordering: exactly one byte per tx handshake. tx_data is stable while tx_valid && !tx_ready. tx_valid drops the cycle after acceptance unless the next byte is ready.
- Timeout: a counter runs in ADDR/LEN/DATA and clears on every rx_valid. On reaching TIMEOUT_CYC, go to TX_STAT(0xE2), with no bus access for the unfinished word; completed burst words remain written. If rx_valid coincides with expiry, the byte wins and the counter clears.
- rx bytes arriving in BUS_*, RD_WAIT, or TX_* states are dropped silently.
- err_cnt increments on acceptance of any 0xE* status byte and saturates at 255.
- busy goes high the cycle after the CMD byte is accepted and low the cycle IDLE is re-entered.

Decomposition:
- Package uart_bridge_pkg holds:
  - opcode constants CMD_WR/CMD_RD/CMD_BWR/CMD_BRD;
  - status constants ST_OK/ST_BADCMD/ST_TIMEOUT/ST_BADLEN;
  - the FSM state enum.
- One sub-module, uart_bridge_timer: loadable down-counter with clear, enable, and expire outputs, parametrised by TIMEOUT_CYC.
- Byte packing/unpacking stays in the top module.

Test Plan:
1. Defaults; rx 01 10 EF BE AD DE -> one bus write to addr 0x10 with wdata 0xDEADBEEF; tx A5; err_cnt 0.
2. Read, bus_rdata=0x11223344 with READ_LAT=2: rx 02 10 -> bus read at 0x10; tx A5 44 33 22 11. Random tx_ready stalls keep tx_data stable.
3. Burst write: rx 03 FE 03 plus 12 data bytes -> writes to addrs 0xFE, 0xFF, 0x00 (wrap); tx A5. Burst read with LEN=2 -> tx A5 then 8 data bytes; addrs increment.
4. Errors:
   - rx 07 -> tx E1.
   - rx 03 10 00 -> tx E3, no bus activity.
   - rx 04 10 11 with MAX_BURST=16 -> tx E3.
   - Afterwards err_cnt = 3.
5. Timeout: TIMEOUT_CYC=50; rx 01 10 AA, then silence -> tx E2 after 50 idle cycles, no bus write. A byte arriving exactly on the expiry cycle is accepted and the frame completes normally.
6. rst asserted mid-burst-read during TX_DATA -> next cycle tx_valid=0, bus_cs=0, busy=0; a subsequent read command then behaves as in scenario 2.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// Shared opcodes, status codes and FSM state encoding for the UART register bridge.
package uart_bridge_pkg;

  localparam logic [7:0] CMD_WR  = 8'h01;
  localparam logic [7:0] CMD_RD  = 8'h02;
  localparam logic [7:0] CMD_BWR = 8'h03;
  localparam logic [7:0] CMD_BRD = 8'h04;

  localparam logic [7:0] ST_OK      = 8'hA5;
  localparam logic [7:0] ST_BADCMD  = 8'hE1;
  localparam logic [7:0] ST_TIMEOUT = 8'hE2;
  localparam logic [7:0] ST_BADLEN  = 8'hE3;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StBusWr,
    StBusRd,
    StRdWait,
    StTxStat,
    StTxData
  } state_e;

  function automatic logic is_valid_cmd(input logic [7:0] cmd);
    return (cmd == CMD_WR) || (cmd == CMD_RD) || (cmd == CMD_BWR) || (cmd == CMD_BRD);
  endfunction

  function automatic logic is_read_cmd(input logic [7:0] cmd);
    return (cmd == CMD_RD) || (cmd == CMD_BRD);
  endfunction

endpackage

// File: rtl/uart_bridge_timer.sv
// Inter-byte timeout: reloads on clear or when disabled, counts down while enabled.
module uart_bridge_timer #(
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i || !en_i) begin
      cnt_q <= CW'(TIMEOUT_CYC - 1);
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - CW'(1);
    end
  end

  // A clear in the expiry cycle wins, so a late-but-just-in-time byte is kept.
  assign expire_o = en_i && !clr_i && (cnt_q == '0);

endmodule

// File: rtl/uart_reg_bridge.sv
// UART byte stream to register bus command bridge with bursts, status bytes and timeout.
module uart_reg_bridge
  import uart_bridge_pkg::*;
#(
  parameter int unsigned ADDR_BYTES  = 1,
  parameter int unsigned DATA_BYTES  = 4,
  parameter int unsigned MAX_BURST   = 16,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned TIMEOUT_CYC = 100000
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rx_valid,
  input  logic [7:0]              rx_data,
  output logic                    tx_valid,
  input  logic                    tx_ready,
  output logic [7:0]              tx_data,
  output logic                    bus_cs,
  output logic                    bus_we,
  output logic [8*ADDR_BYTES-1:0] bus_addr,
  output logic [8*DATA_BYTES-1:0] bus_wdata,
  input  logic [8*DATA_BYTES-1:0] bus_rdata,
  output logic                    busy,
  output logic [7:0]              err_cnt
);

  localparam int unsigned AW = 8 * ADDR_BYTES;
  localparam int unsigned DW = 8 * DATA_BYTES;

  state_e        state_q;
  logic [7:0]    cmd_q;
  logic [7:0]    words_q;
  logic [7:0]    tx_data_q;
  logic [7:0]    err_cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata_q;
  logic [2:0]    byte_cnt_q;
  logic [1:0]    lat_cnt_q;
  logic          first_q;
  logic          tx_valid_q;
  logic          bus_cs_q;
  logic          bus_we_q;

  logic          tmr_en;
  logic          tmr_expire;
  logic          tx_acc;
  logic [AW-1:0] addr_shift;
  logic [DW-1:0] wdata_shift;

  assign tmr_en = (state_q == StAddr) || (state_q == StLen) || (state_q == StData);
  assign tx_acc = tx_valid_q && tx_ready;

  // Fields arrive LSB first: shift each new byte in from the top.
  assign addr_shift  = (addr_q >> 8) | (AW'(rx_data) << (AW - 8));
  assign wdata_shift = (wdata_q >> 8) | (DW'(rx_data) << (DW - 8));

  uart_bridge_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (rx_valid),
    .en_i    (tmr_en),
    .expire_o(tmr_expire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cmd_q      <= '0;
      words_q    <= '0;
      tx_data_q  <= '0;
      err_cnt_q  <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      byte_cnt_q <= '0;
      lat_cnt_q  <= '0;
      first_q    <= 1'b0;
      tx_valid_q <= 1'b0;
      bus_cs_q   <= 1'b0;
      bus_we_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (rx_valid) begin
            cmd_q      <= rx_data;
            byte_cnt_q <= '0;
            if (is_valid_cmd(rx_data)) begin
              state_q <= StAddr;
            end else begin
              tx_data_q  <= ST_BADCMD;
              tx_valid_q <= 1'b1;
              state_q    <= StTxStat;
            end
          end
        end
        StAddr: begin
          if (rx_valid) begin
            addr_q <= addr_shift;
            if (byte_cnt_q == 3'(ADDR_BYTES - 1)) begin
              byte_cnt_q <= '0;
              words_q    <= 8'd1;
              first_q    <= 1'b1;
              case (cmd_q)
                CMD_WR: state_q <= StData;
                CMD_RD: begin
                  state_q  <= StBusRd;
                  bus_cs_q <= 1'b1;
                  bus_we_q <= 1'b0;
                end
                default: state_q <= StLen;
              endcase
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
        StLen: begin
          if (rx_valid) begin
            if (rx_data == 8'd0 || rx_data > 8'(MAX_BURST)) begin
              tx_data_q  <= ST_BADLEN;
              tx_valid_q <= 1'b1;
              state_q    <= StTxStat;
            end else begin
              words_q <= rx_data;
              if (cmd_q == CMD_BWR) begin
                state_q <= StData;
              end else begin
                state_q  <= StBusRd;
                bus_cs_q <= 1'b1;
                bus_we_q <= 1'b0;
              end
            end
          end
        end
        StData: begin
          if (rx_valid) begin
            wdata_q <= wdata_shift;
            if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
              byte_cnt_q <= '0;
              state_q    <= StBusWr;
              bus_cs_q   <= 1'b1;
              bus_we_q   <= 1'b1;
            end else begin
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
        StBusWr: begin
          bus_cs_q <= 1'b0;
          bus_we_q <= 1'b0;
          addr_q   <= addr_q + AW'(1);
          words_q  <= words_q - 8'd1;
          if (words_q != 8'd1) begin
            state_q <= StData;
          end else begin
            tx_data_q  <= ST_OK;
            tx_valid_q <= 1'b1;
            state_q    <= StTxStat;
          end
        end
        StBusRd: begin
          bus_cs_q  <= 1'b0;
          lat_cnt_q <= '0;
          state_q   <= StRdWait;
        end
        StRdWait: begin
          if (lat_cnt_q == 2'(READ_LAT - 1)) begin
            tx_valid_q <= 1'b1;
            byte_cnt_q <= '0;
            if (first_q) begin
              // Status goes out first; the captured word waits in rdata_q.
              first_q   <= 1'b0;
              rdata_q   <= bus_rdata;
              tx_data_q <= ST_OK;
              state_q   <= StTxStat;
            end else begin
              rdata_q   <= bus_rdata >> 8;
              tx_data_q <= bus_rdata[7:0];
              state_q   <= StTxData;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 2'd1;
          end
        end
        StTxStat: begin
          if (tx_acc) begin
            if (tx_data_q == ST_OK && is_read_cmd(cmd_q)) begin
              tx_data_q  <= rdata_q[7:0];
              rdata_q    <= rdata_q >> 8;
              byte_cnt_q <= '0;
              state_q    <= StTxData;
            end else begin
              tx_valid_q <= 1'b0;
              state_q    <= StIdle;
              if (tx_data_q[7:4] == 4'hE && err_cnt_q != 8'hFF) begin
                err_cnt_q <= err_cnt_q + 8'd1;
              end
            end
          end
        end
        StTxData: begin
          if (tx_acc) begin
            if (byte_cnt_q == 3'(DATA_BYTES - 1)) begin
              tx_valid_q <= 1'b0;
              byte_cnt_q <= '0;
              addr_q     <= addr_q + AW'(1);
              words_q    <= words_q - 8'd1;
              if (words_q != 8'd1) begin
                state_q  <= StBusRd;
                bus_cs_q <= 1'b1;
                bus_we_q <= 1'b0;
              end else begin
                state_q <= StIdle;
              end
            end else begin
              tx_data_q  <= rdata_q[7:0];
              rdata_q    <= rdata_q >> 8;
              byte_cnt_q <= byte_cnt_q + 3'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase

      // Only fires in ADDR/LEN/DATA with no byte this cycle; unfinished word is dropped.
      if (tmr_expire) begin
        tx_data_q  <= ST_TIMEOUT;
        tx_valid_q <= 1'b1;
        state_q    <= StTxStat;
      end
    end
  end

  assign tx_valid  = tx_valid_q;
  assign tx_data   = tx_data_q;
  assign bus_cs    = bus_cs_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign busy      = (state_q != StIdle);
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed, table-driven bench for uart_reg_bridge plus timeout and reset sequences.
module tb_uart_reg_bridge;

  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        bus_cs;
  logic        bus_we;
  logic [7:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = 32'hBAD0BAD0;
  logic        busy;
  logic [7:0]  err_cnt;

  int n_tests = 0;
  int n_fail  = 0;
  int stab_err = 0;
  logic stall_en = 1'b0;

  logic [7:0]  tx_log[$];
  logic [40:0] bus_log[$];

  // Byte arrays are packed with element 0 (first sent/expected) in the low byte.
  typedef struct packed {
    logic             stall;
    logic [4:0]       nrx;
    logic [15:0][7:0] rx;
    logic [4:0]       ntx;
    logic [11:0][7:0] tx;
    logic [1:0]       nbus;
    logic [2:0][40:0] bus;
    logic [7:0]       errs;
  } vec_t;

  vec_t vecs[7];

  uart_reg_bridge #(
    .ADDR_BYTES (1),
    .DATA_BYTES (4),
    .MAX_BURST  (16),
    .READ_LAT   (RL),
    .TIMEOUT_CYC(50)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .bus_cs   (bus_cs),
    .bus_we   (bus_we),
    .bus_addr (bus_addr),
    .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata),
    .busy     (busy),
    .err_cnt  (err_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [7:0] a);
    if (a == 8'h10) return 32'h11223344;
    return {a, ~a, a, 8'h5A};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((busy || tx_valid) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({name, " idle_reached"}, 64'(n < 400), 64'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_tx(input string name, input int ntx, input logic [11:0][7:0] tx);
    check({name, " tx_count"}, 64'(tx_log.size()), 64'(ntx));
    for (int k = 0; k < ntx; k++) begin
      if (k < tx_log.size()) check($sformatf("%s tx[%0d]", name, k), 64'(tx_log[k]), 64'(tx[k]));
      else check($sformatf("%s tx[%0d]", name, k), 64'h1FF, 64'(tx[k]));
    end
  endtask

  task automatic check_bus(input string name, input int nbus, input logic [2:0][40:0] bus);
    logic [40:0] e, a;
    check({name, " bus_count"}, 64'(bus_log.size()), 64'(nbus));
    for (int k = 0; k < nbus; k++) begin
      e = bus[k];
      a = (k < bus_log.size()) ? bus_log[k] : 41'h1FFFFFFFFFF;
      if (e[40]) check($sformatf("%s wr[%0d]", name, k), 64'(a), 64'(e));
      else check($sformatf("%s rd[%0d]", name, k), 64'(a[40:32]), 64'(e[40:32]));
    end
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    string nm;
    v  = vecs[i];
    nm = $sformatf("vec%0d", i);
    tx_log.delete();
    bus_log.delete();
    stall_en = v.stall;
    for (int k = 0; k < int'(v.nrx); k++) send_byte(v.rx[k]);
    wait_idle(nm);
    check_tx(nm, int'(v.ntx), v.tx);
    check_bus(nm, int'(v.nbus), v.bus);
    check({nm, " err_cnt"}, 64'(err_cnt), 64'(v.errs));
    stall_en = 1'b0;
  endtask

  // tx_ready driver: random stalls when enabled.
  initial forever begin
    @(posedge clk); #1;
    tx_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
  end

  // Bus read model: data is valid exactly RL cycles after the strobe, garbage otherwise.
  initial begin
    logic        vld_p[RL];
    logic [31:0] dat_p[RL];
    logic        s_vld;
    logic [7:0]  s_adr;
    for (int k = 0; k < RL; k++) begin
      vld_p[k] = 1'b0;
      dat_p[k] = 32'h0;
    end
    forever begin
      @(negedge clk);
      s_vld = bus_cs && !bus_we && !rst;
      s_adr = bus_addr;
      @(posedge clk); #1;
      for (int k = RL - 1; k > 0; k--) begin
        vld_p[k] = vld_p[k-1];
        dat_p[k] = dat_p[k-1];
      end
      vld_p[0] = s_vld;
      dat_p[0] = mem_word(s_adr);
      bus_rdata = vld_p[RL-1] ? dat_p[RL-1] : 32'hBAD0BAD0;
    end
  end

  // Monitor: logs handshakes and bus strobes, checks stall stability.
  initial begin
    logic       pend;
    logic [7:0] held;
    pend = 1'b0;
    held = 8'h00;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend && (!tx_valid || tx_data !== held)) stab_err++;
        if (tx_valid && tx_ready) tx_log.push_back(tx_data);
        if (bus_cs) bus_log.push_back({bus_we, bus_addr, bus_wdata});
        pend = tx_valid && !tx_ready;
        held = tx_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{stall: 1'b0, nrx: 5'd6, rx: 128'hDEADBEEF1001, ntx: 5'd1, tx: 96'hA5,
                nbus: 2'd1, bus: {82'd0, 1'b1, 8'h10, 32'hDEADBEEF}, errs: 8'd0};
    vecs[1] = '{stall: 1'b1, nrx: 5'd2, rx: 128'h1002, ntx: 5'd5, tx: 96'h11223344A5,
                nbus: 2'd1, bus: {82'd0, 1'b0, 8'h10, 32'h0}, errs: 8'd0};
    vecs[2] = '{stall: 1'b0, nrx: 5'd15, rx: 128'h0B0A0908_07060504_03020100_03FE03,
                ntx: 5'd1, tx: 96'hA5, nbus: 2'd3,
                bus: {1'b1, 8'h00, 32'h0B0A0908, 1'b1, 8'hFF, 32'h07060504,
                      1'b1, 8'hFE, 32'h03020100}, errs: 8'd0};
    vecs[3] = '{stall: 1'b1, nrx: 5'd3, rx: 128'h022004, ntx: 5'd9,
                tx: 96'h21DE215A_20DF205A_A5, nbus: 2'd2,
                bus: {41'd0, 1'b0, 8'h21, 32'h0, 1'b0, 8'h20, 32'h0}, errs: 8'd0};
    vecs[4] = '{stall: 1'b0, nrx: 5'd1, rx: 128'h07, ntx: 5'd1, tx: 96'hE1,
                nbus: 2'd0, bus: '0, errs: 8'd1};
    vecs[5] = '{stall: 1'b0, nrx: 5'd3, rx: 128'h001003, ntx: 5'd1, tx: 96'hE3,
                nbus: 2'd0, bus: '0, errs: 8'd2};
    vecs[6] = '{stall: 1'b0, nrx: 5'd3, rx: 128'h111004, ntx: 5'd1, tx: 96'hE3,
                nbus: 2'd0, bus: '0, errs: 8'd3};

    // Reset state
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst tx_valid", 64'(tx_valid), 64'd0);
    check("rst tx_data", 64'(tx_data), 64'd0);
    check("rst bus_cs", 64'(bus_cs), 64'd0);
    check("rst bus_we", 64'(bus_we), 64'd0);
    check("rst bus_addr", 64'(bus_addr), 64'd0);
    check("rst bus_wdata", 64'(bus_wdata), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 7; i++) apply_vec(i);

    // Timeout: E2 exactly 50 idle cycles after the last byte, no bus write
    tx_log.delete();
    bus_log.delete();
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'hAA);
    n = 0;
    while (!tx_valid && n < 100) begin
      @(negedge clk);
      if (!tx_valid) n++;
    end
    check("timeout latency", 64'(n), 64'd50);
    wait_idle("timeout");
    check_tx("timeout", 1, 96'hE2);
    check_bus("timeout", 0, '0);
    check("timeout err_cnt", 64'(err_cnt), 64'd4);

    // Byte landing on the expiry cycle is accepted
    tx_log.delete();
    bus_log.delete();
    send_byte(8'h01);
    send_byte(8'h10);
    send_byte(8'hAA);
    repeat (48) @(posedge clk);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_idle("expiry_edge");
    check_tx("expiry_edge", 1, 96'hA5);
    check_bus("expiry_edge", 1, {82'd0, 1'b1, 8'h10, 32'hDDCCBBAA});

    // Reset during TX_DATA of a burst read
    tx_log.delete();
    bus_log.delete();
    send_byte(8'h04);
    send_byte(8'h20);
    send_byte(8'h02);
    n = 0;
    while (tx_log.size() < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("midrst reached tx_data", 64'(tx_log.size() >= 3), 64'd1);
    check("midrst busy before", 64'(busy), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst tx_valid", 64'(tx_valid), 64'd0);
    check("midrst bus_cs", 64'(bus_cs), 64'd0);
    check("midrst busy", 64'(busy), 64'd0);
    check("midrst err_cnt", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    apply_vec(1);

    check("tx stable while stalled", 64'(stab_err), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
